ones_checksum_checker: RTL

- Receive-side counterpart of the team's 4-bit ones'-complement adder, which produces the transmitted checksum word.
- Accepts a packet of WIDTH-bit words, one per cycle, with the transmitted checksum as the final word.
- Accumulates the words with end-around carry and flags pass when the folded sum equals all-ones (negative zero).
- Sits between the nibble stream source and the lab display/LED logic.

---
 rtl/ones_checksum_checker_if.sv | 30 +++
 rtl/ones_checksum_checker.sv | 104 ++++++++++
 2 files changed

// File: rtl/ones_checksum_checker_if.sv
// Packet stream and result bundle between the nibble source and the checksum checker.
// The master drives packet words; the slave reports handshake and checksum results.
interface ones_checksum_checker_if #(
   parameter int WIDTH     = 4,
   parameter int MAX_WORDS = 16
);
   localparam int CW = $clog2(MAX_WORDS + 1);

   logic             start;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             in_ready;
   logic             busy;
   logic             done;
   logic             pass;
   logic             err;
   logic [WIDTH-1:0] sum;
   logic [CW-1:0]    word_count;

   modport master (
      output start, in_valid, in_data, in_last,
      input  in_ready, busy, done, pass, err, sum, word_count
   );

   modport slave (
      input  start, in_valid, in_data, in_last,
      output in_ready, busy, done, pass, err, sum, word_count
   );
endinterface

// File: rtl/ones_checksum_checker.sv
// Receive-side ones'-complement checksum checker: folds a packet of words with
// end-around carry and passes when the folded sum is all-ones (negative zero).
module ones_checksum_checker #(
   parameter int WIDTH     = 4,
   parameter int MAX_WORDS = 16
) (
   input logic                    clk,
   input logic                    reset,
   ones_checksum_checker_if.slave bus
);
   localparam int CW = $clog2(MAX_WORDS + 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      CHECK,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] sum_q;
   logic [CW-1:0]    count_q;
   logic             ready_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic             err_q;

   logic [WIDTH:0]   wide;
   logic [WIDTH-1:0] folded;

   // The carry out of the first add is fed back in; that second add cannot carry again.
   always_comb begin
      wide   = {1'b0, acc} + {1'b0, bus.in_data};
      folded = wide[WIDTH-1:0] + WIDTH'(wide[WIDTH]);
   end

   // One registered FSM; every output is a flop so the display logic sees clean levels.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         acc     <= '0;
         sum_q   <= '0;
         count_q <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  state   <= ACCUM;
                  acc     <= '0;
                  sum_q   <= '0;
                  count_q <= '0;
                  pass_q  <= 1'b0;
                  err_q   <= 1'b0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            ACCUM: begin
               if (bus.in_valid) begin
                  acc     <= folded;
                  count_q <= count_q + CW'(1);
                  if (bus.in_last) begin
                     state   <= CHECK;
                     ready_q <= 1'b0;
                  end else if (count_q == CW'(MAX_WORDS - 1)) begin
                     // Packet overran its length budget without a checksum word.
                     state   <= CHECK;
                     ready_q <= 1'b0;
                     err_q   <= 1'b1;
                  end
               end
            end
            CHECK: begin
               sum_q  <= acc;
               pass_q <= (acc == '1) && !err_q;
               busy_q <= 1'b0;
               done_q <= 1'b1;
               state  <= DONE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready   = ready_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.err        = err_q;
   assign bus.sum        = sum_q;
   assign bus.word_count = count_q;
endmodule
